pcm_stream_player: RTL
======================

Name: pcm_stream_player

Overview:
- Parametrised stereo PCM clip player; successor to the single-track looping background-music streamer.
- Reads left/right sample ROMs, paces advance by accepted audio writes, and drives the Audio_Controller write interface.
- Adds over the previous block:
  - Play/stop/pause control.
  - Per-play clip bounds.
  - One-shot or loop mode.
  - Volume attenuation.
  - Configurable widths, rate and ROM latency.

Parameters:
- SAMPLE_W, 10: ROM sample width, signed two's complement.
- ADDR_W, 16: ROM address width.
- OUT_W, 32: audio controller sample width. Must satisfy OUT_W >= SAMPLE_W.
- RATE_DIV, 9: accepted writes per sample advance. Must be >= 1.
- ROM_LAT, 1: ROM read latency in cycles. Range 1..3.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- play  in  1  one-cycle start/restart pulse.
- stop  in  1  one-cycle stop pulse.
- pause  in  1  level; holds playback position.
- loop_en  in  1  loop mode; sampled on accepted play.
- clip_start  in  ADDR_W  first sample address; sampled on accepted play.
- clip_end  in  ADDR_W  last sample address, inclusive; sampled on accepted play.
- volume  in  3  right-shift attenuation 0..7; sampled every cycle.
- rom_addr  out  ADDR_W  shared address to both ROMs.
- rom_left_q  in  SAMPLE_W  left ROM data.
- rom_right_q  in  SAMPLE_W  right ROM data.
- audio_out_allowed  in  1  controller FIFO has space.
- write_audio_out  out  1  write strobe to controller.
- left_channel_audio_out  out  OUT_W  left sample.
- right_channel_audio_out  out  OUT_W  right sample.
- busy  out  1  high in PRIME/PLAY.
- done  out  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; rom_addr=0; div_cnt=0.
  - Both channel outputs=0; busy=0; done=0.
- write_audio_out = audio_out_allowed in every state. The controller is always fed; IDLE and PRIME feed silence (0).
- FSM states: IDLE, PRIME, PLAY.
- IDLE:
  - On play: latch start/end/loop_en; rom_addr<=clip_start; lat_cnt<=0; go to PRIME.
  - If clip_end < clip_start, latch end=start (single-sample clip).
- PRIME:
  - Outputs stay 0.
  - After ROM_LAT cycles, load both sample registers from ROM q; div_cnt<=0; go to PLAY.
  - First non-zero output appears ROM_LAT+1 cycles after play.
- PLAY, pause low, audio_out_allowed high:
  - div_cnt increments each cycle.
  - When div_cnt==RATE_DIV-1: div_cnt<=0 and advance.
- Advance rules:
  - addr<end: rom_addr<=addr+1.
  - addr==end, loop: rom_addr<=start.
  - addr==end, one-shot: go to IDLE, outputs<=0, done=1 for one cycle.
  - No address value is skipped or repeated. Exactly RATE_DIV accepted writes occur per sample.
- Data refresh: sample registers reload from ROM q exactly ROM_LAT cycles after each rom_addr change. Between reloads they hold. A ROM_LAT-deep valid shift register tags the reload.
- audio_out_allowed low: div_cnt holds; the address does not advance.
- pause high in PLAY: div_cnt and rom_addr hold; outputs hold the current sample. Resume continues with the same count.
- stop in any state: next cycle state=IDLE, outputs=0, div_cnt=0, done stays 0, in-flight ROM reads are discarded.
- play in PRIME/PLAY: restart from the new clip_start through PRIME; done is not pulsed.
- Priority: reset > stop > play > advance/pause. play and stop in the same cycle → IDLE.
- Scaling, per channel:
  - ext = {sample, (OUT_W-SAMPLE_W) zeros}.
  - out = ext >>> volume (arithmetic shift).
  - Applied at sample register load and again whenever volume changes. Output registered; one-cycle latency from a volume change.
- Address arithmetic is ADDR_W wide. end = 2^ADDR_W-1 with loop wraps to start, never to 0 unless start=0.

Decomposition:
- Package pcm_player_pkg holds:
  - State enum (IDLE, PRIME, PLAY).
  - VOL_W=3.
  - Width-check constants.
- Sub-module pcm_scale: sign-extend, pad and arithmetic-shift one channel. Instantiated twice (left, right).
- The FSM, rate counter and latency pipeline stay in the top.

Test Plan:
- Basic pacing: RATE_DIV=9, ROM_LAT=1, allowed tied high; play with start=10, end=12, loop_en=0. Expected:
  - rom_addr 10 for 9 cycles, then 11, then 12.
  - done pulses 27 cycles after PLAY entry.
  - Outputs return to 0.
- Loop wrap: start=54204, end=54206, loop_en=1. Expected sequence 54204, 54205, 54206, 54204…; never 0 and never 54207.
- Backpressure and pause:
  - Toggle audio_out_allowed 50%: each address held for exactly 9 allowed-high cycles.
  - pause for 20 cycles mid-sample: div_cnt and the output value are unchanged; on resume the remaining count is completed.
- Volume: ROM sample 10'h200 (−512), volume=0 → output 32'h8000_0000. volume=3 → 32'hF000_0000 one cycle later.
- Stop/play collisions:
  - stop during PRIME → IDLE with outputs 0, no done.
  - play+stop in the same cycle → IDLE.
  - play in PLAY at start=100 → PRIME, then rom_addr=100.
- Reset mid-play, plus inverted clip bounds:
  - Assert reset asynchronously mid-cycle: all outputs 0 immediately, busy=0.
  - After release, play with end<start: single-sample clip, done after RATE_DIV writes.

Source files
------------

// File: rtl/pcm_stream_player_pkg.sv
// Shared types and constants for the stereo PCM clip player.
package pcm_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  // Volume is a right-shift amount 0..7.
  localparam int unsigned VOL_W = 3;

  // Supported ROM read latency range and the counter width that covers it.
  localparam int unsigned ROM_LAT_MIN = 1;
  localparam int unsigned ROM_LAT_MAX = 3;
  localparam int unsigned LAT_CNT_W   = $clog2(ROM_LAT_MAX + 1);

  // True when a parameter set is within the supported envelope.
  function automatic bit params_ok(int unsigned sample_w, int unsigned out_w,
                                   int unsigned rate_div, int unsigned rom_lat);
    return (out_w >= sample_w) && (rate_div >= 1) &&
           (rom_lat >= ROM_LAT_MIN) && (rom_lat <= ROM_LAT_MAX);
  endfunction

endpackage

// File: rtl/pcm_stream_player_scale.sv
// One-channel scaler: signed sample left-justified into the output word,
// then arithmetically shifted right by the volume attenuation.
module pcm_scale
  import pcm_player_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned OUT_W    = 32
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [VOL_W-1:0]    volume,
  output logic [OUT_W-1:0]    scaled
);

  localparam int unsigned PAD_W = OUT_W - SAMPLE_W;

  logic signed [SAMPLE_W-1:0] sample_s;
  logic signed [OUT_W-1:0]    ext;

  // Sign-extend then shift left so a zero pad width needs no special case.
  always_comb begin
    sample_s = sample;
    ext      = OUT_W'(sample_s) <<< PAD_W;
    scaled   = ext >>> volume;
  end

endmodule

// File: rtl/pcm_stream_player.sv
// Stereo PCM clip player: walks a [start,end] address range of two sample
// ROMs, advancing once per RATE_DIV accepted writes, and feeds the audio
// controller every cycle (silence outside playback).
module pcm_stream_player
  import pcm_player_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned RATE_DIV = 9,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                play,
  input  logic                stop,
  input  logic                pause,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   clip_start,
  input  logic [ADDR_W-1:0]   clip_end,
  input  logic [VOL_W-1:0]    volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_left_q,
  input  logic [SAMPLE_W-1:0] rom_right_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_channel_audio_out,
  output logic [OUT_W-1:0]    right_channel_audio_out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(ROM_LAT);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     start_q, start_d;
  logic [ADDR_W-1:0]     end_q, end_d;
  logic                  loop_q, loop_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ROM_LAT:0]      vld_q, vld_d;
  logic [SAMPLE_W-1:0]   samp_l_q, samp_l_d;
  logic [SAMPLE_W-1:0]   samp_r_q, samp_r_d;
  logic [OUT_W-1:0]      out_l_q, out_l_d;
  logic [OUT_W-1:0]      out_r_q, out_r_d;
  logic                  done_q, done_d;
  logic [OUT_W-1:0]      scaled_l, scaled_r;

  // Scalers see the next sample value so a reload and its scaling land together.
  pcm_scale #(.SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W)) u_scale_l (
    .sample (samp_l_d),
    .volume (volume),
    .scaled (scaled_l)
  );

  pcm_scale #(.SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W)) u_scale_r (
    .sample (samp_r_d),
    .volume (volume),
    .scaled (scaled_r)
  );

  // Next-state logic: stop beats play, play beats advance/pause.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_d   = start_q;
    end_d     = end_q;
    loop_d    = loop_q;
    div_cnt_d = div_cnt_q;
    lat_cnt_d = lat_cnt_q;
    samp_l_d  = samp_l_q;
    samp_r_d  = samp_r_q;
    done_d    = 1'b0;
    // Tag bit 0 marks the first cycle a new address is presented; the
    // matching ROM data is captured when the tag reaches the top stage.
    vld_d     = {vld_q[ROM_LAT-1:0], 1'b0};

    if (stop) begin
      state_d   = ST_IDLE;
      div_cnt_d = '0;
      vld_d     = '0;
    end else if (play) begin
      start_d   = clip_start;
      end_d     = (clip_end < clip_start) ? clip_start : clip_end;
      loop_d    = loop_en;
      addr_d    = clip_start;
      lat_cnt_d = '0;
      div_cnt_d = '0;
      vld_d     = '0;
      state_d   = ST_PRIME;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vld_d = '0;
        end
        ST_PRIME: begin
          vld_d = '0;
          if (lat_cnt_q == LAT_LAST) begin
            samp_l_d  = rom_left_q;
            samp_r_d  = rom_right_q;
            div_cnt_d = '0;
            state_d   = ST_PLAY;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (vld_q[ROM_LAT]) begin
            samp_l_d = rom_left_q;
            samp_r_d = rom_right_q;
          end
          if (!pause && audio_out_allowed) begin
            if (div_cnt_q == DIV_LAST) begin
              div_cnt_d = '0;
              if (addr_q < end_q) begin
                addr_d   = addr_q + 1'b1;
                vld_d[0] = 1'b1;
              end else if (loop_q) begin
                addr_d   = start_q;
                vld_d[0] = 1'b1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                vld_d   = '0;
              end
            end else begin
              div_cnt_d = div_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          vld_d   = '0;
        end
      endcase
    end

    // Outputs are silent outside PLAY; in PLAY they track sample and volume.
    if (state_d == ST_PLAY) begin
      out_l_d = scaled_l;
      out_r_d = scaled_r;
    end else begin
      out_l_d = '0;
      out_r_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      loop_q    <= 1'b0;
      div_cnt_q <= '0;
      lat_cnt_q <= '0;
      vld_q     <= '0;
      samp_l_q  <= '0;
      samp_r_q  <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      end_q     <= end_d;
      loop_q    <= loop_d;
      div_cnt_q <= div_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      vld_q     <= vld_d;
      samp_l_q  <= samp_l_d;
      samp_r_q  <= samp_r_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      done_q    <= done_d;
    end
  end

  assign rom_addr                = addr_q;
  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;
  assign busy                    = (state_q != ST_IDLE);
  assign done                    = done_q;

endmodule
